// File: rtl/count_display.sv
// count_display: sequential binary-to-BCD converter driving a multiplexed 3-digit 7-segment display
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   count_in   10-bit binary count, nominally 0-999
//   bcd        latched BCD result {hundreds, tens, ones}
//   bcd_valid  one-cycle pulse when bcd updates
//   busy       conversion in progress
//   ovf        last sampled count_in exceeded 999
//   seg        segment drive, active-high, gfedcba
//   an         one-hot digit enable: [0] ones, [1] tens, [2] hundreds
module count_display #(
    parameter int REFRESH_DIV = 4,
    parameter bit LEAD_BLANK  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  count_in,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [2:0]  an
);
    localparam int RW = $clog2(REFRESH_DIV);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [9:0]    last_sample;
    logic [21:0]   work, adj, sh;
    logic [3:0]    bit_cnt;
    logic          start, done;
    logic [RW-1:0] rcnt;
    logic [1:0]    dig, dig_n;
    logic [3:0]    nib;
    logic          blank, wrap;
    logic [6:0]    seg_n;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        start   = state == IDLE && count_in != last_sample;
        done    = state == SHIFT && bit_cnt == 4'd9;
        state_n = start ? SHIFT : done ? IDLE : state;
        // add-3 on each BCD nibble, then shift the whole {bcd_work, bin} register
        adj     = {add3(work[21:18]), add3(work[17:14]), add3(work[13:10]), work[9:0]};
        sh      = adj << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_sample <= '0;
            work        <= '0;
            bit_cnt     <= '0;
            bcd         <= '0;
            bcd_valid   <= 1'b0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            bcd_valid <= done;
            if (start) begin
                last_sample <= count_in;
                work        <= {12'd0, count_in > 10'd999 ? 10'd999 : count_in};
                ovf         <= count_in > 10'd999;
                bit_cnt     <= '0;
                busy        <= 1'b1;
            end else if (state == SHIFT) begin
                work    <= sh;
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (done) begin
                bcd  <= sh[21:10];
                busy <= 1'b0;
            end
        end
    end

    // seg is computed for the digit about to be enabled, so an and seg change together
    always_comb begin
        wrap  = rcnt == RW'(REFRESH_DIV - 1);
        dig_n = dig == 2'd2 ? 2'd0 : dig + 2'd1;
        nib   = dig_n == 2'd0 ? bcd[3:0] : dig_n == 2'd1 ? bcd[7:4] : bcd[11:8];
        blank = LEAD_BLANK && ((dig_n == 2'd2 && bcd[11:8] == 4'd0) || (dig_n == 2'd1 && bcd[11:4] == 8'd0));
        seg_n = blank ? 7'h00 : dec7(nib);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt <= '0;
            dig  <= 2'd0;
            an   <= 3'b001;
            seg  <= 7'h3F;
        end else begin
            rcnt <= wrap ? '0 : rcnt + RW'(1);
            if (wrap) begin
                dig <= dig_n;
                an  <= 3'b001 << dig_n;
                seg <= seg_n;
            end
        end
    end
endmodule

// File: tb/tb_count_display.sv
// tb_count_display: table-driven check of conversion, overflow, blanking and reset behaviour
module tb_count_display;
    localparam int R = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  count_in = '0;
    logic [11:0] bcd;
    logic        bcd_valid, busy, ovf;
    logic [6:0]  seg;
    logic [2:0]  an;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0]  v;
        logic [11:0] b;
        logic        o;
        bit          c;
        logic [6:0]  s0, s1, s2;
    } vec_t;
    vec_t tbl[11];

    count_display #(.REFRESH_DIV(R), .LEAD_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .bcd(bcd), .bcd_valid(bcd_valid),
        .busy(busy), .ovf(ovf), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic conv(input logic [9:0] v, input logic [11:0] eb, input logic eo, input bit ec);
        int n;
        count_in = v;
        tick;
        if (ec) chk("busy_start", busy, 1);
        n = 0;
        while (!bcd_valid && n < 20) begin
            tick;
            n++;
            if (ec && !bcd_valid) chk("busy_hold", busy, 1);
        end
        if (ec) begin
            chk("latency", n, 10);
            chk("busy_end", busy, 0);
        end else chk("no_conv", bcd_valid, 0);
        chk("bcd", bcd, eb);
        chk("ovf", ovf, eo);
        tick;
        chk("pulse_width", bcd_valid, 0);
    endtask

    task automatic disp(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        logic [7:0] s0, s1, s2;
        s0 = 8'h80;
        s1 = 8'h80;
        s2 = 8'h80;
        repeat (3 * R + 1) tick;
        for (int i = 0; i < 3 * R; i++) begin
            tick;
            if (an == 3'b001) s0 = {1'b0, seg};
            else if (an == 3'b010) s1 = {1'b0, seg};
            else if (an == 3'b100) s2 = {1'b0, seg};
        end
        chk("seg_ones", s0, {1'b0, e0});
        chk("seg_tens", s1, {1'b0, e1});
        chk("seg_hund", s2, {1'b0, e2});
    endtask

    initial begin
        logic [11:0] res[2];
        int nv;
        tbl[0]  = '{10'd123,  12'h123, 1'b0, 1'b1, 7'h4F, 7'h5B, 7'h06};
        tbl[1]  = '{10'd999,  12'h999, 1'b0, 1'b1, 7'h6F, 7'h6F, 7'h6F};
        tbl[2]  = '{10'd1023, 12'h999, 1'b1, 1'b1, 7'h6F, 7'h6F, 7'h6F};
        tbl[3]  = '{10'd1023, 12'h999, 1'b1, 1'b0, 7'h6F, 7'h6F, 7'h6F};
        tbl[4]  = '{10'd7,    12'h007, 1'b0, 1'b1, 7'h07, 7'h00, 7'h00};
        tbl[5]  = '{10'd40,   12'h040, 1'b0, 1'b1, 7'h3F, 7'h66, 7'h00};
        tbl[6]  = '{10'd58,   12'h058, 1'b0, 1'b1, 7'h7F, 7'h6D, 7'h00};
        tbl[7]  = '{10'd700,  12'h700, 1'b0, 1'b1, 7'h3F, 7'h3F, 7'h07};
        tbl[8]  = '{10'd1000, 12'h999, 1'b1, 1'b1, 7'h6F, 7'h6F, 7'h6F};
        tbl[9]  = '{10'd999,  12'h999, 1'b0, 1'b1, 7'h6F, 7'h6F, 7'h6F};
        tbl[10] = '{10'd0,    12'h000, 1'b0, 1'b1, 7'h3F, 7'h00, 7'h00};

        repeat (3) tick;
        rst = 1'b1;
        chk("rst_bcd", bcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_an", an, 3'b001);
        chk("rst_seg", seg, 7'h3F);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("rst_no_valid", bcd_valid, 0);
            chk("rst_an_step", an, i < 4 ? 3'b001 : 3'b010);
        end

        foreach (tbl[i]) begin
            conv(tbl[i].v, tbl[i].b, tbl[i].o, tbl[i].c);
            disp(tbl[i].s0, tbl[i].s1, tbl[i].s2);
        end

        nv = 0;
        count_in = 10'd5;
        tick;
        count_in = 10'd6;
        tick;
        count_in = 10'd7;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bcd_valid) begin
                if (nv < 2) res[nv] = bcd;
                nv++;
            end
        end
        chk("b2b_count", nv, 2);
        chk("b2b_first", res[0], 12'h005);
        chk("b2b_second", res[1], 12'h007);

        count_in = 10'd456;
        tick;
        repeat (4) begin
            tick;
            chk("mid_no_valid", bcd_valid, 0);
        end
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("mid_rst_bcd", bcd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", bcd_valid, 0);
        conv(10'd456, 12'h456, 1'b0, 1'b1);
        disp(7'h7D, 7'h6D, 7'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
